// File: rtl/vector_stream_sequencer.sv
// Streams one vector bank out through the UART transmitter, MSB byte first per element.
// Walks addresses 0..DEPTH-1 once per READ_A/READ_B command and holds busy for the whole walk.
module vector_stream_sequencer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        command,
    output logic              mem_rd_en,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_HOLD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic              sel_reg, sel_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] shift_left;
    logic              accept;

    // A command coinciding with reset must not be reported busy to the decoder.
    assign accept = (state_reg == S_IDLE) && !rst &&
                    ((command == 3'd1) || (command == 3'd2));

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_shift
            if (gi == 0) begin : g_low
                assign shift_left[7:0] = 8'h00;
            end else begin : g_up
                assign shift_left[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            sel_reg   <= 1'b0;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        mem_rd_en  = 1'b0;
        tx_start   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    sel_next   = (command == 3'd2);
                    addr_next  = '0;
                    cnt_next   = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en  = !rst;
                state_next = S_LATCH;
            end
            S_LATCH: begin
                shift_next = mem_rdata;
                cnt_next   = '0;
                state_next = S_SEND;
            end
            S_SEND: begin
                // Gated by rst so a reset cycle never launches a fresh byte.
                if (!tx_busy) begin
                    tx_start   = !rst;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                shift_next = shift_left;
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (cnt_reg < LAST_BYTE) begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = S_SEND;
                    end else if (addr_reg == LAST_ADDR) begin
                        state_next = S_DONE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy = ((state_reg != S_IDLE) && (state_reg != S_DONE)) || accept;
    end

    assign mem_sel  = sel_reg;
    assign mem_addr = addr_reg;
    assign tx_data  = shift_reg[DATA_W-1 -: 8];

endmodule

// File: tb/tb_vector_stream_sequencer.sv
// Bench for vector_stream_sequencer: memory and UART models, scoreboard queues for
// addresses and bytes, a small command decoder model, and a table of transfers.
module tb_vector_stream_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 16;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        command;
    logic [2:0]        cmd_drv = 3'd0;
    logic              mem_rd_en;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic              busy;

    vector_stream_sequencer #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .command  (command),
        .mem_rd_en(mem_rd_en),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int tx_cnt = 0;
    int cyc = 0;
    int uart_hold = 1;
    int u_cnt = 0;
    logic exp_sel = 1'b0;
    logic prev_start = 1'b0;

    logic [DATA_W-1:0] bank_a [DEPTH];
    logic [DATA_W-1:0] bank_b [DEPTH];
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [7:0]        exp_byte_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Vector memory: registered read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_sel ? bank_b[mem_addr] : bank_a[mem_addr];
    end

    // UART transmitter: busy rises the cycle after a start and stays up uart_hold cycles.
    always @(posedge clk) begin
        if (tx_busy) begin
            if (u_cnt <= 1) tx_busy <= 1'b0;
            u_cnt <= u_cnt - 1;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            u_cnt   <= uart_hold;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cnt++;
            if (exp_addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else begin
                check("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("rd_sel", 32'(mem_sel), 32'(exp_sel));
            end
        end
        if (tx_start) begin
            tx_cnt++;
            check("tx_while_busy", 32'(tx_busy), 32'd0);
            check("tx_back_to_back", 32'(prev_start), 32'd0);
            check("tx_in_rst", 32'(rst), 32'd0);
            if (exp_byte_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
            else check("tx_byte", 32'(tx_data), 32'(exp_byte_q.pop_front()));
        end
        prev_start = tx_start;
    end

    // Command decoder model with a registered copy of busy.
    typedef enum logic [1:0] {D_IDLE, D_READ_A, D_BUSY} dstate_t;
    dstate_t    dec_state = D_IDLE;
    logic       busy_q = 1'b0;
    logic       dec_mode = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_char = 8'h00;
    int         match_idx = 0;
    logic [2:0] dec_cmd;

    function automatic logic [7:0] want_char(input int i);
        case (i)
            0:       return 8'h72;
            1:       return 8'h61;
            default: return 8'h0a;
        endcase
    endfunction

    always @(posedge clk) begin
        busy_q <= busy;
        if (rst) begin
            dec_state <= D_IDLE;
            match_idx <= 0;
        end else begin
            case (dec_state)
                D_IDLE: if (rx_valid) begin
                    if (rx_char == want_char(match_idx)) begin
                        if (match_idx == 2) begin
                            dec_state <= D_READ_A;
                            match_idx <= 0;
                        end else match_idx <= match_idx + 1;
                    end else match_idx <= 0;
                end
                D_READ_A: dec_state <= D_BUSY;
                D_BUSY:   if (!busy_q) dec_state <= D_IDLE;
                default:  dec_state <= D_IDLE;
            endcase
        end
    end

    always_comb begin
        dec_cmd = 3'd0;
        if (dec_state == D_READ_A) dec_cmd = 3'd1;
        else if (dec_state == D_BUSY) dec_cmd = 3'd3;
        command = dec_mode ? dec_cmd : cmd_drv;
    end

    typedef struct {
        logic [2:0]               cmd;
        logic [3:0][DATA_W-1:0]   data;
        int                       hold;
        int                       exp_cycles;
    } vec_t;
    vec_t tbl [3];

    task automatic push_expected(input logic sel);
        exp_sel = sel;
        rd_cnt  = 0;
        tx_cnt  = 0;
        for (int e = 0; e < DEPTH; e++) begin
            logic [DATA_W-1:0] d;
            d = sel ? bank_b[e] : bank_a[e];
            exp_addr_q.push_back(ADDR_W'(e));
            exp_byte_q.push_back(d[15:8]);
            exp_byte_q.push_back(d[7:0]);
        end
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic end_checks();
        check("rd_count", 32'(rd_cnt), 32'(DEPTH));
        check("tx_count", 32'(tx_cnt), 32'(DEPTH * BYTES));
        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("byte_q_empty", 32'(exp_byte_q.size()), 32'd0);
        check("busy_low_in_done", 32'(busy), 32'd0);
    endtask

    task automatic run_xfer(input logic [2:0] cmd, input int hold, input int exp_cycles);
        int n;
        push_expected(cmd == 3'd2);
        uart_hold = hold;
        @(negedge clk);
        cmd_drv = cmd;
        #1 check("accept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        cmd_drv = 3'd0;
        wait_busy_low(n);
        check("busy_cycles", 32'(n + 1), 32'(exp_cycles));
        end_checks();
        @(negedge clk);
        $display("xfer cmd=%0d hold=%0d busy_cycles=%0d rd=%0d tx=%0d", cmd, hold, n + 1, rd_cnt, tx_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int t_fall;

        tbl[0].cmd = 3'd1; tbl[0].data = {16'hFF00, 16'h0001, 16'hABCD, 16'h1234};
        tbl[0].hold = 1;   tbl[0].exp_cycles = 1 + DEPTH * (2 + BYTES * 3);
        tbl[1].cmd = 3'd2; tbl[1].data = {16'h5555, 16'h5555, 16'h5555, 16'h5555};
        tbl[1].hold = 1;   tbl[1].exp_cycles = 1 + DEPTH * (2 + BYTES * 3);
        tbl[2].cmd = 3'd1; tbl[2].data = {16'hFF00, 16'h0001, 16'hABCD, 16'h1234};
        tbl[2].hold = 10;  tbl[2].exp_cycles = 1 + DEPTH * (2 + BYTES * 12);
        for (int e = 0; e < DEPTH; e++) begin
            bank_a[e] = '0;
            bank_b[e] = '0;
        end

        // Command held together with reset must be ignored.
        rst = 1'b1;
        cmd_drv = 3'd1;
        repeat (3) @(negedge clk);
        check("busy_during_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        cmd_drv = 3'd0;
        @(negedge clk);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_sel", 32'(mem_sel), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        repeat (5) @(negedge clk);
        check("rst_cmd_ignored_busy", 32'(busy), 32'd0);
        check("rst_cmd_ignored_rd", 32'(rd_cnt), 32'd0);
        $display("reset checks done");

        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (tbl[i].cmd == 3'd2) bank_b[e] = tbl[i].data[e];
                else bank_a[e] = tbl[i].data[e];
            end
            run_xfer(tbl[i].cmd, tbl[i].hold, tbl[i].exp_cycles);
        end

        // Re-issued READ_A mid-transfer and BUSY held throughout: no restart.
        push_expected(1'b0);
        uart_hold = 3;
        @(negedge clk);
        cmd_drv = 3'd1;
        @(negedge clk);
        cmd_drv = 3'd3;
        repeat (10) @(negedge clk);
        cmd_drv = 3'd1;
        @(negedge clk);
        cmd_drv = 3'd3;
        wait_busy_low(n);
        cmd_drv = 3'd0;
        end_checks();
        repeat (5) @(negedge clk);
        check("no_restart_rd", 32'(rd_cnt), 32'(DEPTH));
        check("no_restart_busy", 32'(busy), 32'd0);
        $display("repeat-command xfer rd=%0d tx=%0d", rd_cnt, tx_cnt);

        // Decoder integration: "ra\n" drives READ_A then BUSY.
        push_expected(1'b0);
        uart_hold = 1;
        dec_mode = 1'b1;
        @(negedge clk); rx_valid = 1'b1; rx_char = 8'h72;
        @(negedge clk); rx_char = 8'h61;
        @(negedge clk); rx_char = 8'h0a;
        @(negedge clk); rx_valid = 1'b0;
        n = 0;
        while (dec_state != D_BUSY && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dec_enters_busy", 32'(dec_state), 32'(D_BUSY));
        bad = 0;
        n = 0;
        while (busy && n < 3000) begin
            if (dec_state != D_BUSY) bad++;
            n++;
            @(negedge clk);
        end
        t_fall = cyc;
        check("dec_busy_hold", 32'(bad), 32'd0);
        n = 0;
        while (dec_state != D_IDLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("dec_idle_delay", 32'(cyc - t_fall), 32'd2);
        end_checks();
        dec_mode = 1'b0;
        @(negedge clk);
        $display("decoder xfer rd=%0d tx=%0d idle_delay=%0d", rd_cnt, tx_cnt, cyc - t_fall);

        // Reset after the third byte, then a clean READ_B transfer.
        push_expected(1'b0);
        uart_hold = 1;
        @(negedge clk);
        cmd_drv = 3'd1;
        @(negedge clk);
        cmd_drv = 3'd0;
        n = 0;
        while (tx_cnt < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("third_byte_seen", 32'(tx_cnt), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        exp_addr_q.delete();
        exp_byte_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("midrst_mem_sel", 32'(mem_sel), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("no_tx_after_rst", 32'(tx_cnt), 32'd3);
        check("no_rd_after_rst", 32'(rd_cnt), 32'd2);
        $display("mid-transfer reset tx=%0d rd=%0d", tx_cnt, rd_cnt);
        bank_b[0] = 16'h0102;
        bank_b[1] = 16'h0304;
        bank_b[2] = 16'h0506;
        bank_b[3] = 16'h0708;
        run_xfer(3'd2, 1, 1 + DEPTH * (2 + BYTES * 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
